// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_pkg
//  Brief    : Shared state encoding and counter sizing for the serial multiplier.
//  Revision : 1.0
// ============================================================================
package mul_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/ser_mul_sign_abs.sv
`default_nettype none
// ============================================================================
//  Module   : sign_abs
//  Brief    : Conditional two's-complement magnitude and sign extraction.
//  Revision : 1.0
// ============================================================================
module sign_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_is_signed,
    output logic [WIDTH-1:0] o_abs,
    output logic             o_neg
);

    logic w_neg;

    // Negating the most negative value yields 2^(WIDTH-1), still correct as unsigned.
    assign w_neg = i_is_signed & i_x[WIDTH-1];
    assign o_neg = w_neg;
    assign o_abs = w_neg ? (~i_x + {{(WIDTH-1){1'b0}}, 1'b1}) : i_x;

endmodule : sign_abs
`default_nettype wire

// File: rtl/ser_mul.sv
`default_nettype none
// ============================================================================
//  Module   : ser_mul
//  Brief    : Radix-2 shift-add multiplier producing the full 2*WIDTH product.
//  Revision : 1.0
// ============================================================================
module ser_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic             i_a_signed,
    input  logic             i_b_signed,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_busy,
    output logic             o_end_valid,
    output logic [WIDTH-1:0] o_product_lo,
    output logic [WIDTH-1:0] o_product_hi
);

    localparam int            CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] c_cnt_init = CW'(WIDTH - 1);

    mul_state_e         r_state;
    mul_state_e         w_next_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic               r_end_valid;
    logic [WIDTH-1:0]   r_prod_lo;
    logic [WIDTH-1:0]   r_prod_hi;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_final;

    sign_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_x         (i_op_a),
        .i_is_signed (i_a_signed),
        .o_abs       (w_abs_a),
        .o_neg       (w_neg_a)
    );

    sign_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_x         (i_op_b),
        .i_is_signed (i_b_signed),
        .o_abs       (w_abs_b),
        .o_neg       (w_neg_b)
    );

    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    // A zero magnitude negates back to zero, so no special case is needed.
    assign w_final = r_neg ? (~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_acc;

    always_comb begin
        w_next_state = r_state;
        if (i_flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (i_start) w_next_state = CALC;
                CALC:    if (r_cnt == '0) w_next_state = DONE;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_neg       <= 1'b0;
            r_end_valid <= 1'b0;
            r_prod_lo   <= '0;
            r_prod_hi   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_end_valid <= 1'b0;
            if (i_flush) begin
                r_cnt     <= '0;
                r_prod_lo <= '0;
                r_prod_hi <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_mcand  <= w_abs_a;
                            r_mplier <= w_abs_b;
                            r_neg    <= w_neg_a ^ w_neg_b;
                            r_acc    <= '0;
                            r_cnt    <= c_cnt_init;
                        end
                    end
                    CALC: begin
                        r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                        r_mplier <= r_mplier >> 1;
                        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    end
                    DONE: begin
                        r_prod_lo   <= w_final[WIDTH-1:0];
                        r_prod_hi   <= w_final[2*WIDTH-1:WIDTH];
                        r_end_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_busy       = (r_state != IDLE);
    assign o_end_valid  = r_end_valid;
    assign o_product_lo = r_prod_lo;
    assign o_product_hi = r_prod_hi;

endmodule : ser_mul
`default_nettype wire
